fft_frame_sequencer: RTL
========================

# fft_frame_sequencer

Frame-level scheduler for the FFT datapath. Accepts a stream of audio samples, sequences the FFT control unit through load (bit-reversed write of N samples), compute (one-cycle `start`, wait for `done`) and drain (bin readout with ready/valid backpressure), then repeats while enabled. It sits between the sample front end and `fft_control_unit`/FFT RAMs on one side and the pitch/peak logic on the other.

## Interface
- `N`, 512, FFT length in samples; power of two.
- `M`, 9, log2(N); width of sample and bin indices.
- `TIMEOUT`, 8192, maximum cycles spent in WAIT before abort.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run frames continuously while high.
- `sample_valid`  in  1  front-end sample present.
- `sample_ready`  out  1  high only in LOAD.
- `sample_we`  out  1  `sample_valid & sample_ready`; FFT input write strobe.
- `load`  out  1  drives `fft_control_unit.load`; high in LOAD.
- `rd_adr`  out  M  natural-order sample index; drives `fft_control_unit.rd_adr`.
- `start`  out  1  one-cycle FFT start pulse.
- `done`  in  1  FFT complete (level).
- `bin_adr`  out  M  bin readout address.
- `bin_valid`  out  1  `bin_adr` valid for transfer.
- `bin_ready`  in  1  consumer accepts current bin.
- `bin_last`  out  1  with `bin_valid` on final bin.
- `bin_data_valid`  out  1  registered handshake; RAM data for previous `bin_adr` valid this cycle.
- `busy`  out  1  state != IDLE.
- `frame_count`  out  16  completed frames, wraps.
- `drop_count`  out  16  samples offered while not LOAD, saturating.
- `error`  out  1  sticky WAIT timeout.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE: `enable`=1 → LOAD, index cleared.
- LOAD: each `sample_we` writes at `rd_adr`, then increments. Accepting index N-1 → START.
- START: `start`=1 for exactly one cycle → WAIT; WAIT timer cleared.
- WAIT: `done`=1 → DRAIN with `bin_adr`=0. Timer reaching TIMEOUT-1 with `done`=0 sets `error` and goes to IDLE. No frame is counted.
- DRAIN: `bin_valid`=1; transfer on `bin_valid & bin_ready`; `bin_adr` advances per transfer and holds otherwise. Transfer of last bin → `frame_count`+1, then LOAD if `enable` else IDLE.
- `enable` falling mid-frame: current frame completes; IDLE afterward.
- `sample_valid` outside LOAD increments `drop_count`, saturating at 0xFFFF. `sample_valid` in LOAD is never dropped.
- `error` clears only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `sample_ready`/`load` are registered state decodes, high from the first LOAD cycle.
- LOAD→START: the cycle after the N-th accept. `start` follows the last `sample_we` by exactly one cycle.
- WAIT→DRAIN: one cycle after `done` is sampled high.
- `bin_data_valid` = registered `bin_valid & bin_ready`. Assumes 1-cycle synchronous RAM read.
- Full-rate drain with `bin_ready` held high: one bin per cycle.
- `done` already high on WAIT entry: DRAIN next cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.

## Configuration
- `FFT_SEQ_HALF_DRAIN_EN` defined: drain bins 0..N/2-1 only (real-input symmetry); `bin_last` at N/2-1.
- Undefined: drain all N bins; `bin_last` at N-1.

## Structure
- Shared `fft_pkg` holds:
  - `N`/`M` defaults
  - the `seq_state_t` enum
  - a `BIN_LAST` constant selected by the macro.
- Sub-module `sat_counter` (width param, inc, clear) is used for `drop_count`. The other counters stay inline.

## Test plan
- Reset, `enable`=1, 512 back-to-back samples → `rd_adr` 0..511, `start` pulses once on the cycle after sample 511, `busy`=1.
- `done` after 40 cycles, `bin_ready`=1 → `bin_adr` 0..511 (0..255 with macro). `bin_last` on final bin, `bin_data_valid` lags one cycle, `frame_count`=1.
- `bin_ready` toggling 1,0,0,1 during drain → `bin_adr` holds during stalls; no bin skipped or repeated.
- 10 samples offered during WAIT → `drop_count`=10; 70000 offered → saturates at 0xFFFF.
- `done` never asserted → `error`=1 after TIMEOUT cycles in WAIT, state IDLE, `frame_count` unchanged.
- `enable` dropped during LOAD → frame completes through DRAIN, then IDLE. Reset mid-DRAIN → all outputs 0 immediately.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default transform size, sequencer state encoding
// and the final drained bin index.
// Build option: FFT_SEQ_HALF_DRAIN_EN limits the drain to bins 0..N/2-1.
package fft_pkg;

  localparam int FFT_N       = 512;
  localparam int FFT_M       = 9;
  localparam int FFT_TIMEOUT = 8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } seq_state_t;

  // Index of the last bin handed to the consumer for an n-point transform.
  // With real input the upper half mirrors the lower half, so it can be skipped.
  function automatic int last_bin(input int n);
`ifdef FFT_SEQ_HALF_DRAIN_EN
    return n / 2 - 1;
`else
    return n - 1;
`endif
  endfunction

  localparam int BIN_LAST = last_bin(FFT_N);

endpackage

// File: rtl/fft_frame_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count events, stick at the maximum value.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the FFT datapath: load N samples (bit reversal is done
// by fft_control_unit from rd_adr), pulse start, wait for done, then drain
// the bins with ready/valid backpressure. Repeats while enable is high.
// Build option: FFT_SEQ_HALF_DRAIN_EN drains only bins 0..N/2-1.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int M       = FFT_M,
  parameter int TIMEOUT = FFT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         sample_we,
  output logic         load,
  output logic [M-1:0] rd_adr,
  output logic         start,
  input  logic         done,
  output logic [M-1:0] bin_adr,
  output logic         bin_valid,
  input  logic         bin_ready,
  output logic         bin_last,
  output logic         bin_data_valid,
  output logic         busy,
  output logic [15:0]  frame_count,
  output logic [15:0]  drop_count,
  output logic         error
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [M-1:0]  LAST_SAMPLE = M'(N - 1);
  localparam logic [M-1:0]  LAST_BIN    = M'(last_bin(N));
  localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [TW-1:0] timer;
  logic          xfer;
  logic          last_accept;
  logic          last_xfer;
  logic          timeout_hit;

  // Outputs are decodes of the state flop, so they are glitch-free registers.
  assign sample_ready = (state == ST_LOAD);
  assign load         = sample_ready;
  assign sample_we    = sample_valid & sample_ready;
  assign start        = (state == ST_START);
  assign bin_valid    = (state == ST_DRAIN);
  assign bin_last     = bin_valid & (bin_adr == LAST_BIN);
  assign busy         = (state != ST_IDLE);

  assign xfer        = bin_valid & bin_ready;
  assign last_accept = sample_we & (rd_adr == LAST_SAMPLE);
  assign last_xfer   = xfer & (bin_adr == LAST_BIN);
  assign timeout_hit = (state == ST_WAIT) & ~done & (timer == TIMER_MAX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; enable is only consulted at frame boundaries so a
  // frame in flight always runs to completion.
  // NOTE: state_nxt is assigned before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_LOAD;
      ST_LOAD:  if (last_accept) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done)             state_nxt = ST_DRAIN;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (last_xfer) state_nxt = enable ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sample index, watchdog timer, bin address and frame bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_adr         <= '0;
      bin_adr        <= '0;
      timer          <= '0;
      frame_count    <= '0;
      error          <= 1'b0;
      bin_data_valid <= 1'b0;
    end else begin
      // RAM read data for the address accepted this cycle appears next cycle.
      bin_data_valid <= xfer;
      case (state)
        ST_IDLE: rd_adr <= '0;
        // N is a power of two, so the index wraps back to 0 after the last accept.
        ST_LOAD: if (sample_we) rd_adr <= rd_adr + M'(1);
        ST_START: timer <= '0;
        ST_WAIT: begin
          timer   <= timer + TW'(1);
          bin_adr <= '0;
          if (timeout_hit) error <= 1'b1;
        end
        ST_DRAIN: begin
          if (xfer) begin
            bin_adr <= bin_adr + M'(1);
            if (last_xfer) begin
              frame_count <= frame_count + 16'd1;
              rd_adr      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Samples offered while not loading are counted, never written.
  sat_counter #(
    .W (16)
  ) u_drop_counter (
    .clk   (clk),
    .rst_n (reset),
    .inc   (sample_valid & ~sample_ready),
    .clear (1'b0),
    .count (drop_count)
  );

endmodule
